dmem_arbiter: RTL and testbench

- Sits between the CPU data port, a debug/DMA port and the single-port data memory (16-bit x 2048, asynchronous read, clocked write).
- After reset it runs a loader sequence that writes the program's initial variable table into memory.
- After loading, it shares the memory between the two requesters with a two-way round-robin arbiter.
- Exactly one access reaches memory per cycle.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/rr_arb2.sv | 62 ++++++
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, enums and loader table for the data-memory arbiter.
// Optional debug lock is enabled with DMEM_ARB_LOCK_EN.
package dmem_pkg;

  localparam int DMEM_ADDR_W     = 11;
  localparam int DMEM_DATA_W     = 16;
  localparam int DMEM_INIT_WORDS = 8;

  typedef enum logic {
    INIT,
    ARB
  } state_e;

  typedef enum logic {
    CPU,
    DBG
  } port_e;

  function automatic logic [DMEM_DATA_W-1:0] init_word(
    input logic [DMEM_ADDR_W-1:0] idx,
    input logic                   sel
  );
    logic [DMEM_DATA_W-1:0] w;
    case (idx)
      11'd0:   w = sel ? 16'h0008 : 16'h0007;
      11'd1:   w = sel ? 16'h0003 : 16'h0005;
      11'd2:   w = 16'h0003;
      11'd3:   w = 16'h0005;
      11'd4:   w = 16'h5A5A;
      11'd5:   w = 16'h6767;
      11'd6:   w = 16'h003C;
      11'd7:   w = 16'h00FF;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with priority register.
// DMEM_ARB_LOCK_EN adds a debug-side grant lock.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  en_i,
  input  logic  req_cpu_i,
  input  logic  req_dbg_i,
`ifdef DMEM_ARB_LOCK_EN
  input  logic  lock_i,
`endif
  output logic  gnt_cpu_o,
  output logic  gnt_dbg_o
);

  port_e prio_q, prio_d;
  logic  lock_act;

`ifdef DMEM_ARB_LOCK_EN
  logic lock_q, lock_d;

  assign lock_act = lock_q & req_dbg_i;
  assign lock_d   = en_i & gnt_dbg_o & lock_i;

  always_ff @(posedge clk) begin
    if (!reset) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end
`else
  assign lock_act = 1'b0;
`endif

  always_comb begin
    gnt_cpu_o = 1'b0;
    gnt_dbg_o = 1'b0;
    if (en_i) begin
      if (lock_act) begin
        gnt_dbg_o = 1'b1;
      end else if (req_cpu_i && req_dbg_i) begin
        gnt_cpu_o = (prio_q == CPU);
        gnt_dbg_o = (prio_q == DBG);
      end else begin
        gnt_cpu_o = req_cpu_i;
        gnt_dbg_o = req_dbg_i;
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt_cpu_o)      prio_d = DBG;
    else if (gnt_dbg_o) prio_d = CPU;
  end

  always_ff @(posedge clk) begin
    if (!reset) prio_q <= CPU;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Loader then round-robin sharing of one data memory by CPU and debug.
// Define DMEM_ARB_LOCK_EN to add the dbg_lock input.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int INIT_WORDS = DMEM_INIT_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              loadControl,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adrx,
  input  logic [DATA_W-1:0] cpu_dataIn,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_dataOut,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_adrx,
  input  logic [DATA_W-1:0] dbg_dataIn,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_dataOut,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              dbg_lock,
`endif
  output logic [ADDR_W-1:0] mem_adrx,
  output logic [DATA_W-1:0] mem_dataIn,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_dataOut,
  output logic              init_done
);

  localparam int CNT_W = (INIT_WORDS > 1) ? $clog2(INIT_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(INIT_WORDS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic             done_q, done_d;
  logic             ld_sel_q;
  logic             gnt_cpu, gnt_dbg;
  logic             arb_en;

  assign arb_en    = reset && (state_q == ARB);
  assign init_done = done_q;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .en_i      (arb_en),
    .req_cpu_i (cpu_req),
    .req_dbg_i (dbg_req),
`ifdef DMEM_ARB_LOCK_EN
    .lock_i    (dbg_lock),
`endif
    .gnt_cpu_o (gnt_cpu),
    .gnt_dbg_o (gnt_dbg)
  );

  // Table select follows loadControl only while reset is held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      done_q     <= 1'b0;
      ld_sel_q   <= loadControl;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    done_d     = done_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + CNT_W'(1);
      if (init_cnt_q == LAST) begin
        state_d = ARB;
        done_d  = 1'b1;
      end
    end
  end

  always_comb begin
    mem_write   = 1'b0;
    mem_adrx    = '0;
    mem_dataIn  = '0;
    cpu_ack     = 1'b0;
    dbg_ack     = 1'b0;
    cpu_dataOut = '0;
    dbg_dataOut = '0;
    if (reset) begin
      if (state_q == INIT) begin
        mem_write  = 1'b1;
        mem_adrx   = ADDR_W'(init_cnt_q);
        mem_dataIn = DATA_W'(init_word(DMEM_ADDR_W'(init_cnt_q),
                                       ld_sel_q));
      end else begin
        unique case (1'b1)
          gnt_cpu: begin
            mem_adrx    = cpu_adrx;
            mem_dataIn  = cpu_dataIn;
            mem_write   = cpu_we;
            cpu_ack     = 1'b1;
            cpu_dataOut = mem_dataOut;
          end
          gnt_dbg: begin
            mem_adrx    = dbg_adrx;
            mem_dataIn  = dbg_dataIn;
            mem_write   = dbg_we;
            dbg_ack     = 1'b1;
            dbg_dataOut = mem_dataOut;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory model.
// Lock cases run only when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        loadControl;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [10:0] cpu_adrx, dbg_adrx, mem_adrx;
  logic [15:0] cpu_dataIn, dbg_dataIn, mem_dataIn;
  logic [15:0] cpu_dataOut, dbg_dataOut, mem_dataOut;
  logic        cpu_ack, dbg_ack, mem_write, init_done;
`ifdef DMEM_ARB_LOCK_EN
  logic        dbg_lock;
`endif

  int errs   = 0;
  int checks = 0;

  logic [15:0] mem [0:2047];
  logic [15:0] tbl0 [0:7];
  logic [15:0] tbl1 [0:7];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_adrx] <= mem_dataIn;
  end
  assign mem_dataOut = mem[mem_adrx];

  dmem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .loadControl (loadControl),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_adrx    (cpu_adrx),
    .cpu_dataIn  (cpu_dataIn),
    .cpu_ack     (cpu_ack),
    .cpu_dataOut (cpu_dataOut),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_adrx    (dbg_adrx),
    .dbg_dataIn  (dbg_dataIn),
    .dbg_ack     (dbg_ack),
    .dbg_dataOut (dbg_dataOut),
`ifdef DMEM_ARB_LOCK_EN
    .dbg_lock    (dbg_lock),
`endif
    .mem_adrx    (mem_adrx),
    .mem_dataIn  (mem_dataIn),
    .mem_write   (mem_write),
    .mem_dataOut (mem_dataOut),
    .init_done   (init_done)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input logic sel, input int n);
    reset       = 1'b0;
    loadControl = sel;
    for (int i = 0; i < n; i++) begin
      tick();
      @(negedge clk);
      check("rst_we",   mem_write,   0);
      check("rst_cack", cpu_ack,     0);
      check("rst_dack", dbg_ack,     0);
      check("rst_cdo",  cpu_dataOut, 0);
      check("rst_done", init_done,   0);
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic run_loader(input logic sel, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("ld_we",   mem_write, 1);
      check("ld_adr",  mem_adrx, k);
      check("ld_dat",  mem_dataIn, sel ? tbl1[k] : tbl0[k]);
      check("ld_done", init_done, 0);
      check("ld_cack", cpu_ack, 0);
      check("ld_dack", dbg_ack, 0);
      tick();
    end
  endtask

  task automatic req(input logic cr, input logic cw,
                     input logic [10:0] ca, input logic [15:0] cd,
                     input logic dr, input logic dw,
                     input logic [10:0] da, input logic [15:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_adrx = ca; cpu_dataIn = cd;
    dbg_req = dr; dbg_we = dw; dbg_adrx = da; dbg_dataIn = dd;
  endtask

  task automatic expect_arb(input string tag,
                            input logic ca, input logic da,
                            input logic [15:0] cdo,
                            input logic [15:0] ddo,
                            input logic we,
                            input logic [10:0] adr);
    @(negedge clk);
    check({tag, "_cack"}, cpu_ack, ca);
    check({tag, "_dack"}, dbg_ack, da);
    check({tag, "_cdo"},  cpu_dataOut, cdo);
    check({tag, "_ddo"},  dbg_dataOut, ddo);
    check({tag, "_we"},   mem_write, we);
    check({tag, "_adr"},  mem_adrx, adr);
    check({tag, "_done"}, init_done, 1);
    tick();
  endtask

  initial begin
    tbl0 = '{16'h0007, 16'h0005, 16'h0003, 16'h0005,
             16'h5A5A, 16'h6767, 16'h003C, 16'h00FF};
    tbl1 = '{16'h0008, 16'h0003, 16'h0003, 16'h0005,
             16'h5A5A, 16'h6767, 16'h003C, 16'h00FF};
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
`ifdef DMEM_ARB_LOCK_EN
    dbg_lock = 1'b0;
`endif
    req(0, 0, 0, 0, 0, 0, 0, 0);

    // Loader with default table; CPU requests throughout INIT.
    hold_reset(1'b0, 2);
    req(1, 0, 11'd0, 0, 0, 0, 0, 0);
    run_loader(1'b0, 8);
    expect_arb("first", 1, 0, 16'h0007, 0, 0, 11'd0);
    req(0, 0, 0, 0, 1, 0, 11'd1, 0);
    expect_arb("dbg1", 0, 1, 0, 16'h0005, 0, 11'd1);

    // Continuous contention alternates, CPU first.
    req(1, 0, 11'd2, 0, 1, 0, 11'd3, 0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) expect_arb("rr", 1, 0, 16'h0003, 0, 0, 11'd2);
      else            expect_arb("rr", 0, 1, 0, 16'h0005, 0, 11'd3);
    end

    // CPU-only write then read-back, then write-during-read.
    req(1, 1, 11'h010, 16'h1234, 0, 0, 0, 0);
    expect_arb("cwr", 1, 0, 16'h0000, 0, 1, 11'h010);
    req(1, 0, 11'h010, 0, 0, 0, 0, 0);
    expect_arb("crd", 1, 0, 16'h1234, 0, 0, 11'h010);
    req(1, 1, 11'h010, 16'hBEEF, 0, 0, 0, 0);
    expect_arb("cold", 1, 0, 16'h1234, 0, 1, 11'h010);
    req(1, 0, 11'h010, 0, 0, 0, 0, 0);
    expect_arb("cnew", 1, 0, 16'hBEEF, 0, 0, 11'h010);
    req(0, 0, 11'h055, 0, 0, 0, 11'h066, 0);
    expect_arb("idle", 0, 0, 0, 0, 0, 11'd0);

    // Alternate table, reset mid-loader restarts at address 0.
    hold_reset(1'b1, 1);
    run_loader(1'b1, 4);
    hold_reset(1'b1, 1);
    run_loader(1'b1, 8);
    req(0, 0, 0, 0, 1, 0, 11'd0, 0);
    expect_arb("alt0", 0, 1, 0, 16'h0008, 0, 11'd0);

`ifdef DMEM_ARB_LOCK_EN
    // prio is CPU here; DBG locks after its first grant.
    hold_reset(1'b0, 1);
    req(0, 0, 0, 0, 0, 0, 0, 0);
    run_loader(1'b0, 8);
    req(1, 0, 11'd2, 0, 1, 0, 11'd3, 0);
    dbg_lock = 1'b1;
    expect_arb("lk0", 1, 0, 16'h0003, 0, 0, 11'd2);
    for (int i = 0; i < 4; i++)
      expect_arb("lk", 0, 1, 0, 16'h0005, 0, 11'd3);
    dbg_lock = 1'b0;
    expect_arb("lkrel", 0, 1, 0, 16'h0005, 0, 11'd3);
    expect_arb("lkcpu", 1, 0, 16'h0003, 0, 0, 11'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
